// File: rtl/sample_ring_ctrl_if.sv
// sample_ring_ctrl_if: sample input, scan request, RAM control and peak report bundle for sample_ring_ctrl
interface sample_ring_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int ADDR = 8
);
  logic sample_valid;
  logic [WIDTH-1:0] sample;
  logic scan_start;
  logic [ADDR-1:0] ram_addr;
  logic ram_rw;
  logic ram_wen;
  logic [WIDTH-1:0] peak;
  logic peak_valid;
  logic busy;
  logic drop;
  modport master (
    input sample_valid, sample, scan_start,
    output ram_addr, ram_rw, ram_wen, peak, peak_valid, busy, drop
  );
  modport slave (
    output sample_valid, sample, scan_start,
    input ram_addr, ram_rw, ram_wen, peak, peak_valid, busy, drop
  );
endinterface

// File: rtl/sample_ring_ctrl.sv
// sample_ring_ctrl: ring-buffer sample writer and peak scanner over a single-port RAM; define PEAK_DECAY_EN for a falling-bar peak
module sample_ring_ctrl #(
  parameter int WIDTH = 8,
  parameter int ADDR = 8
) (
  input logic clk,
  input logic rst,
  sample_ring_ctrl_if.master bus,
  inout wire [WIDTH-1:0] ram_data
);
  localparam logic [ADDR:0] FULL = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] ONE = {{ADDR{1'b0}}, 1'b1};
  typedef enum logic [1:0] {IDLE, WRITE, SCAN} state_t;
  state_t state, next;
  logic [ADDR-1:0] wr_ptr, rd_ptr;
  logic [ADDR:0] count, remaining;
  logic [WIDTH-1:0] hold, acc, acc_next, peak_new;
  logic hold_full, scan_pend, in_scan, accept, last, done;
  assign accept = state == IDLE && !hold_full && (bus.scan_start || scan_pend);
  assign last = state == SCAN && remaining == ONE;
  assign done = last || (accept && count == '0);
  assign acc_next = ram_data > acc ? ram_data : acc;
  assign ram_data = state == WRITE ? hold : 'z;
  assign bus.busy = in_scan;
`ifdef PEAK_DECAY_EN
  logic [WIDTH-1:0] decayed, result;
  assign decayed = bus.peak == '0 ? '0 : bus.peak - 1'b1;
  assign result = last ? acc_next : '0;
  assign peak_new = result > decayed ? result : decayed;
`else
  assign peak_new = last ? acc_next : '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  // A pending write always goes first; a scan interrupted by one resumes where it left off.
  always_comb begin
    next = state;
    bus.ram_rw = 1'b0;
    bus.ram_wen = 1'b0;
    bus.ram_addr = '0;
    case (state)
      IDLE: next = hold_full ? WRITE : (accept && count != '0) ? SCAN : IDLE;
      WRITE: begin
        next = in_scan ? SCAN : IDLE;
        bus.ram_rw = 1'b1;
        bus.ram_wen = 1'b1;
        bus.ram_addr = wr_ptr;
      end
      SCAN: begin
        next = last ? IDLE : hold_full ? WRITE : SCAN;
        bus.ram_addr = rd_ptr;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      remaining <= '0;
      hold <= '0;
      acc <= '0;
      hold_full <= 1'b0;
      scan_pend <= 1'b0;
      in_scan <= 1'b0;
      bus.peak <= '0;
      bus.peak_valid <= 1'b0;
      bus.drop <= 1'b0;
    end else begin
      hold_full <= state == WRITE ? bus.sample_valid : hold_full | bus.sample_valid;
      if (bus.sample_valid && (!hold_full || state == WRITE)) hold <= bus.sample;
      bus.drop <= bus.sample_valid && hold_full && state != WRITE;
      scan_pend <= !accept && (scan_pend || (bus.scan_start && !in_scan));
      if (state == WRITE) begin
        wr_ptr <= wr_ptr + 1'b1;
        count <= count == FULL ? count : count + 1'b1;
      end
      if (accept) begin
        rd_ptr <= wr_ptr - count[ADDR-1:0];
        remaining <= count;
        acc <= '0;
        in_scan <= count != '0;
      end
      if (state == SCAN) begin
        rd_ptr <= rd_ptr + 1'b1;
        remaining <= remaining - 1'b1;
        acc <= acc_next;
      end
      if (last) in_scan <= 1'b0;
      bus.peak_valid <= done;
      if (done) bus.peak <= peak_new;
    end
  end
endmodule

// File: tb/tb_sample_ring_ctrl.sv
// tb_sample_ring_ctrl: directed and randomized checks of sample_ring_ctrl against a most-recent-window peak model
`timescale 1ns/1ps
module tb_sample_ring_ctrl;
  localparam int W = 8;
  localparam int A = 3;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  wire [W-1:0] ram_data;
  logic [W-1:0] mem [D];
  int wq[$];
  int rq[$];
  int win[$];
  int s1[4] = '{10, 200, 35, 7};
  int s2[4] = '{5, 9, 3, 1};
  int passed = 0;
  int failed = 0;
  int total = 0;
  int last_peak = 0;
  int rw_err = 0;
  sample_ring_ctrl_if #(.WIDTH(W), .ADDR(A)) bus();
  sample_ring_ctrl #(.WIDTH(W), .ADDR(A)) dut (.clk(clk), .rst(rst), .bus(bus), .ram_data(ram_data));
  always #5 clk = ~clk;
  // Behavioural RAM: combinational read, write on the edge closing a write cycle.
  assign ram_data = bus.ram_rw ? 'z : mem[bus.ram_addr];
  always @(posedge clk) if (bus.ram_rw && bus.ram_wen) mem[bus.ram_addr] <= ram_data;
  always @(negedge clk) if (!rst) begin
    if (bus.ram_wen != bus.ram_rw) rw_err++;
    if (bus.ram_wen) wq.push_back(int'(bus.ram_addr));
    else if (bus.busy && !bus.ram_rw) rq.push_back(int'(bus.ram_addr));
  end
  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic push(int v);
    win.push_back(v);
    if (win.size() > D) void'(win.pop_front());
  endtask
  function automatic int expect_peak();
    int m = 0;
    foreach (win[i]) if (win[i] > m) m = win[i];
`ifdef PEAK_DECAY_EN
    if (last_peak - 1 > m) m = last_peak - 1;
`endif
    return m;
  endfunction
  task automatic do_reset;
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.scan_start = 1'b0;
    bus.sample = '0;
    step;
    step;
    rst = 1'b0;
    win.delete();
    last_peak = 0;
  endtask
  task automatic send(int v);
    bus.sample_valid = 1'b1;
    bus.sample = W'(v);
    step;
    bus.sample_valid = 1'b0;
    step;
    step;
    push(v);
  endtask
  // Scan with an optional sample strobed in cycle inj of the scan (0 = none).
  task automatic scan(string tag, int inj, int v);
    int lat = 0;
    int exp_lat;
    int b1 = 0;
    exp_lat = (win.size() == 0 ? 1 : win.size() + 1) + (inj > 0 ? 1 : 0);
    rq.delete();
    wq.delete();
    bus.scan_start = 1'b1;
    while (lat < 40) begin
      step;
      bus.scan_start = 1'b0;
      bus.sample_valid = 1'b0;
      lat++;
      if (lat == 1) b1 = int'(bus.busy);
      if (bus.peak_valid) break;
      if (lat == inj) begin
        bus.sample_valid = 1'b1;
        bus.sample = W'(v);
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " peak"}, int'(bus.peak), expect_peak());
    chk({tag, " busy during"}, b1, int'(win.size() != 0));
    chk({tag, " busy after"}, int'(bus.busy), 0);
    chk({tag, " reads"}, rq.size(), win.size());
    chk({tag, " writes"}, wq.size(), int'(inj > 0));
    last_peak = expect_peak();
    if (inj > 0) push(v);
  endtask
  initial begin
    do_reset;
    chk("rst addr", int'(bus.ram_addr), 0);
    chk("rst rw", int'(bus.ram_rw), 0);
    chk("rst wen", int'(bus.ram_wen), 0);
    chk("rst peak", int'(bus.peak), 0);
    chk("rst peak_valid", int'(bus.peak_valid), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst drop", int'(bus.drop), 0);
    scan("empty", 0, 0);
    chk("empty peak0", int'(bus.peak), 0);
    wq.delete();
    foreach (s1[i]) send(s1[i]);
    chk("case1 nwrites", wq.size(), 4);
    foreach (wq[i]) chk("case1 waddr", wq[i], i);
    foreach (s1[i]) chk("case1 wdata", int'(mem[i]), s1[i]);
    scan("case1", 0, 0);
    chk("case1 peak200", int'(bus.peak), 200);
    foreach (rq[i]) chk("case1 raddr", rq[i], i);
    do_reset;
    for (int v = 1; v <= 10; v++) send(v);
    scan("wrap", 0, 0);
    chk("wrap peak10", int'(bus.peak), 10);
    foreach (rq[i]) chk("wrap raddr", rq[i], (2 + i) % D);
    do_reset;
    foreach (s2[i]) send(s2[i]);
    scan("insert", 1, 250);
    chk("insert peak9", int'(bus.peak), 9);
    foreach (rq[i]) chk("insert raddr", rq[i], i);
    foreach (wq[i]) chk("insert waddr", wq[i], 4);
    repeat (3) step;
    scan("after insert", 0, 0);
    do_reset;
    bus.sample_valid = 1'b1;
    bus.sample = 8'd77;
    step;
    bus.sample = 8'd88;
    chk("drop early", int'(bus.drop), 0);
    step;
    bus.sample_valid = 1'b0;
    chk("drop pulse", int'(bus.drop), 1);
    step;
    chk("drop single", int'(bus.drop), 0);
    step;
    step;
    push(77);
    scan("drop", 0, 0);
    chk("drop kept first", int'(bus.peak), 77);
    do_reset;
    send(50);
    scan("decay a", 0, 0);
    repeat (8) send(0);
    scan("decay b", 0, 0);
`ifdef PEAK_DECAY_EN
    chk("decay peak", int'(bus.peak), 49);
`else
    chk("decay peak", int'(bus.peak), 0);
`endif
    for (int it = 0; it < 20; it++) begin
      int n;
      int c;
      int inj;
      n = int'($urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) do_reset;
      for (int j = 0; j < n; j++) begin
        send(int'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) step;
      end
      c = win.size();
      inj = c >= 3 ? int'($urandom_range(0, c - 2)) : 0;
      scan("rand", inj, int'($urandom_range(0, 255)));
      repeat (3) step;
    end
    chk("rw wen agree", rw_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
